// File: rtl/sbox7_preimage_if.sv
// sbox7_preimage_if: request/response bundle for the S7 preimage enumerator
interface sbox7_preimage_if;
  logic       req_valid;
  logic [3:0] req_data;
  logic       req_ready;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [6:1] out_data;
  logic [1:0] out_row;
  logic       out_last;
  logic       busy;
  modport master (
    output req_valid, req_data, abort, out_ready,
    input  req_ready, out_valid, out_data, out_row, out_last, busy
  );
  modport slave (
    input  req_valid, req_data, abort, out_ready,
    output req_ready, out_valid, out_data, out_row, out_last, busy
  );
endinterface

// File: rtl/sbox7_preimage.sv
// sbox7_preimage: scans the DES S7 table and streams the four inputs mapping to a requested nibble
module sbox7_preimage (
  input  logic              clk,
  input  logic              rst_n,
  sbox7_preimage_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
  // Rows 0..3 concatenated; entry for sel s sits at bit offset 4*(63-s)
  localparam logic [255:0] S7 = {
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C
  };
  state_t     state, state_d;
  logic [5:0] idx, idx_d;
  logic [3:0] y, y_d;
  logic [6:1] data_q, data_d;
  logic [1:0] row_q, row_d;
  logic       last_q, last_d;
  logic [3:0] entry;
  logic       hit;
  assign entry = S7[{~idx, 2'b00} +: 4];
  assign hit   = entry == y;
  always_comb begin
    state_d = state;
    idx_d   = idx;
    y_d     = y;
    data_d  = data_q;
    row_d   = row_q;
    last_d  = last_q;
    case (state)
      IDLE: if (bus.req_valid) begin
        y_d     = bus.req_data;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: if (bus.abort) state_d = IDLE;
      else if (hit) begin
        data_d  = {idx[5], idx[3:0], idx[4]};
        row_d   = idx[5:4];
        last_d  = &idx[5:4];
        state_d = EMIT;
      end else idx_d = idx + 6'd1;
      EMIT: if (bus.abort) state_d = IDLE;
      else if (bus.out_ready) begin
        state_d = last_q ? IDLE : SCAN;
        idx_d   = last_q ? idx : idx + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      y      <= '0;
      data_q <= '0;
      row_q  <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      y      <= y_d;
      data_q <= data_d;
      row_q  <= row_d;
      last_q <= last_d;
    end
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == EMIT;
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_sbox7_preimage.sv
// tb_sbox7_preimage: directed checks of the S7 preimage enumerator
module tb_sbox7_preimage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sbox7_preimage_if bus();
  sbox7_preimage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [3:0] s7tab [64];
  logic [63:0] rows [4] = '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                            64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
  logic [6:1] exp0 [4] = '{6'h0A, 6'h03, 6'h38, 6'h35};
  logic [6:1] expc [4] = '{6'h12, 6'h17, 6'h28, 6'h3F};
  int gap0 [4] = '{6, 12, 27, 14};

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 100);
  endtask

  task automatic accept(input logic [3:0] y);
    bus.req_data = y;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_data = '0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    #3;
    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ready got ready=%b busy=%b want 1/0", bus.req_ready, bus.busy); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_valid got valid=%b last=%b want 0/0", bus.out_valid, bus.out_last); end
    checks++; if (bus.out_data !== 6'h00 || bus.out_row !== 2'd0) begin errors++; $display("FAIL reset_data got data=%h row=%0d want 00/0", bus.out_data, bus.out_row); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle got ready=%b want 1", bus.req_ready); end
  endtask

  task automatic test_y0_stream;
    int n;
    bus.out_ready = 1'b1;
    accept(4'h0);
    checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL y0_busy got busy=%b ready=%b want 1/0", bus.busy, bus.req_ready); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      wait_valid(n);
      checks++; if (n != gap0[k]) begin errors++; $display("FAIL y0_latency[%0d] got %0d edges want %0d", k, n, gap0[k]); end
      checks++; if (bus.out_data !== exp0[k]) begin errors++; $display("FAIL y0_data[%0d] got %h want %h", k, bus.out_data, exp0[k]); end
      checks++; if (bus.out_row !== k[1:0] || bus.out_last !== (k == 3)) begin errors++; $display("FAIL y0_row_last[%0d] got row=%0d last=%b want %0d/%b", k, bus.out_row, bus.out_last, k, k == 3); end
    end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL y0_done got ready=%b valid=%b want 1/0", bus.req_ready, bus.out_valid); end
  endtask

  task automatic test_stall;
    int got = 0;
    int cyc = 0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    logic [6:1] prev_d = '0;
    logic prev_l = 1'b0;
    bus.out_ready = 1'b1;
    accept(4'hC);
    while (got < 4 && cyc < 400) begin
      bus.out_ready = (cyc % 2 == 0);
      if (bus.out_valid) begin
        if (prev_v && !prev_r) begin
          checks++; if (bus.out_data !== prev_d || bus.out_last !== prev_l) begin errors++; $display("FAIL stall_hold got %h/%b want %h/%b", bus.out_data, bus.out_last, prev_d, prev_l); end
        end
        if (bus.out_ready) begin
          checks++; if (bus.out_data !== expc[got] || bus.out_last !== (got == 3)) begin errors++; $display("FAIL stall_data[%0d] got %h/%b want %h/%b", got, bus.out_data, bus.out_last, expc[got], got == 3); end
          got++;
        end
      end
      prev_v = bus.out_valid; prev_r = bus.out_ready; prev_d = bus.out_data; prev_l = bus.out_last;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != 4 || bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_done got count=%0d ready=%b valid=%b want 4/1/0", got, bus.req_ready, bus.out_valid); end
  endtask

  task automatic test_exhaustive;
    int n;
    logic [63:0] seen = '0;
    logic [6:1] x;
    bus.out_ready = 1'b1;
    for (int y = 0; y < 16; y++) begin
      accept(y[3:0]);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        wait_valid(n);
        x = bus.out_data;
        checks++; if (n >= 100 || s7tab[{x[6], x[1], x[5:2]}] !== y[3:0]) begin errors++; $display("FAIL exh_map y=%h got x=%h wait=%0d", y, x, n); end
        checks++; if (seen[x]) begin errors++; $display("FAIL exh_dup y=%h got repeated x=%h want fresh", y, x); end
        seen[x] = 1'b1;
        checks++; if (bus.out_row !== k[1:0] || bus.out_row !== {x[6], x[1]} || bus.out_last !== (k == 3)) begin errors++; $display("FAIL exh_row y=%h k=%0d got row=%0d last=%b want %0d/%b", y, k, bus.out_row, bus.out_last, k, k == 3); end
      end
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL exh_done y=%h got ready=%b want 1", y, bus.req_ready); end
    end
    checks++; if (seen !== {64{1'b1}}) begin errors++; $display("FAIL exh_cover got %h want all ones", seen); end
  endtask

  task automatic test_abort;
    int n;
    int bad = 0;
    bus.out_ready = 1'b0;
    accept(4'h0);
    wait_valid(n);
    checks++; if (bus.out_data !== 6'h0A) begin errors++; $display("FAIL abort_first got %h want 0a", bus.out_data); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    wait_valid(n);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 6'h03) begin errors++; $display("FAIL abort_second got valid=%b data=%h want 1/03", bus.out_valid, bus.out_data); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_emit got valid=%b ready=%b want 0/1", bus.out_valid, bus.req_ready); end
    bus.out_ready = 1'b1;
    repeat (70) begin @(posedge clk); #1; if (bus.out_valid) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_silent got %0d valid cycles want 0", bad); end
    accept(4'hC);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      wait_valid(n);
      checks++; if (bus.out_data !== expc[k]) begin errors++; $display("FAIL abort_next[%0d] got %h want %h", k, bus.out_data, expc[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort_idle_scan;
    bus.abort = 1'b1;
    accept(4'h5);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_idle_accept got busy=%b want 1", bus.busy); end
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++; if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_scan got ready=%b valid=%b want 1/0", bus.req_ready, bus.out_valid); end
  endtask

  task automatic test_back_to_back_hold;
    int n;
    bus.out_ready = 1'b1;
    bus.req_data = 4'h0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_data = 4'hC;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      wait_valid(n);
      checks++; if (bus.out_data !== exp0[k]) begin errors++; $display("FAIL hold_data[%0d] got %h want %h", k, bus.out_data, exp0[k]); end
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL hold_done got ready=%b want 1", bus.req_ready); end
  endtask

  task automatic test_async_reset;
    int n;
    accept(4'hC);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_scan got ready=%b busy=%b valid=%b want 1/0/0", bus.req_ready, bus.busy, bus.out_valid); end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    accept(4'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0; end
      wait_valid(n);
    end
    checks++; if (bus.out_last !== 1'b1 || bus.out_data !== 6'h35 || bus.out_row !== 2'd3) begin errors++; $display("FAIL rst_pre got last=%b data=%h row=%0d want 1/35/3", bus.out_last, bus.out_data, bus.out_row); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 6'h00 || bus.out_row !== 2'd0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_emit got valid=%b last=%b data=%h row=%0d ready=%b want 0/0/00/0/1", bus.out_valid, bus.out_last, bus.out_data, bus.out_row, bus.req_ready); end
    bus.out_ready = 1'b1;
    bus.req_data = 4'h0;
    bus.req_valid = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_release_accept got busy=%b want 1", bus.busy); end
    wait_valid(n);
    checks++; if (n != 6 || bus.out_data !== 6'h0A) begin errors++; $display("FAIL rst_release_first got %0d edges data=%h want 6/0a", n, bus.out_data); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        s7tab[r * 16 + c] = rows[r][(63 - 4 * c) -: 4];
    test_reset;
    test_y0_stream;
    test_stall;
    test_exhaustive;
    test_abort;
    test_abort_idle_scan;
    test_back_to_back_hold;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sbox7_preimage.md
SBOX7_PREIMAGE -- requirements
Module: sbox7_preimage

Interface
REQ-001 The block SHALL have no parameters; the S7 table SHALL be fixed internal constant data.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 REQ_VALID  input  1  request present.
REQ-005 REQ_DATA  input  [3:0]  S7 output nibble y whose preimages are wanted.
REQ-006 REQ_READY  output  1  block idle and able to accept a request.
REQ-007 ABORT  input  1  synchronous cancel of the current request.
REQ-008 OUT_VALID  output  1  OUT_DATA/OUT_ROW/OUT_LAST hold a valid preimage.
REQ-009 OUT_READY  input  1  downstream accepts the preimage.
REQ-010 OUT_DATA  output  [6:1]  6-bit S7 input x with S7(x)=y, in native input bit order.
REQ-011 OUT_ROW  output  [1:0]  row {x[6],x[1]} of this preimage.
REQ-012 OUT_LAST  output  1  marks the 4th (final) preimage of the request.
REQ-013 BUSY  output  1  request in progress; equals ~REQ_READY.

Function
REQ-014 The S7 table SHALL be indexed by sel={x[6],x[1],x[5:2]} with rows (cols 0..15, hex): r0 4B2EF08D3C975A61, r1 D0B749 1AE35C2F86, r2 14BDC37EAF6805 92, r3 6BD814A7950FE23C (spaces not significant).
REQ-015 States SHALL be IDLE, SCAN, EMIT; only IDLE drives REQ_READY=1.
REQ-016 IDLE: on REQ_VALID&REQ_READY at an edge, REQ_DATA SHALL be latched, 6-bit index idx cleared to 0, state -> SCAN.
REQ-017 SCAN: each cycle table[idx] SHALL be compared to latched y; no match -> idx+1; match -> capture OUT_DATA={idx[5],idx[3:0],idx[4]}, OUT_ROW=idx[5:4], OUT_LAST=(idx[5:4]==3), state -> EMIT.
REQ-018 OUT_VALID SHALL be 1 exactly in EMIT; OUT_DATA/OUT_ROW/OUT_LAST SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 EMIT with OUT_READY=1: if OUT_LAST -> IDLE; else idx+1 and -> SCAN.
REQ-020 Preimages SHALL be emitted in ascending sel order, exactly one per row (rows are permutations), exactly 4 per request.
REQ-021 Latency: OUT_VALID SHALL rise c+1 edges after the accept edge, c = sel of first match; subsequent outputs rise (c'-c) edges after the previous OUT_VALID&OUT_READY edge.
REQ-022 idx SHALL never wrap; reaching the row-3 match always terminates the request.
REQ-023 ABORT=1 in SCAN or EMIT SHALL force IDLE at the next edge, OUT_VALID=0, no further outputs; ABORT in IDLE SHALL be ignored and SHALL not block a same-cycle accept.
REQ-024 ABORT coincident with OUT_VALID&OUT_READY: the handshake SHALL count as delivered, then IDLE.
REQ-025 REQ_VALID while busy SHALL be ignored (not latched).
REQ-026 OUT_DATA/OUT_ROW/OUT_LAST values outside EMIT are don't-care for checkers.

Reset
REQ-027 RST_N=0 SHALL immediately force IDLE, REQ_READY=1, BUSY=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, OUT_ROW=0, idx=0, latched y=0, regardless of CLK.
REQ-028 Reset asserted mid-request SHALL discard it; after release the first edge with REQ_VALID=1 SHALL be accepted.

Verification
REQ-029 y=0x0, OUT_READY=1 always -> OUT_DATA 0x0A,0x03,0x38,0x35 (rows 0..3), OUT_LAST only on 0x35; first OUT_VALID 6 edges after accept, last at sel 58.
REQ-030 y=0xC with OUT_READY toggling 1/0 -> 0x12,0x17,0x28,0x3F, outputs held stable during stalls, no duplicates or drops.
REQ-031 Exhaustive: all 16 y values -> each yields 4 outputs; the 64 outputs in total cover every x in 0x00..0x3F once; each S7(x)=y per table.
REQ-032 ABORT during EMIT of y=0x0 second output (0x03, OUT_READY=0) -> OUT_VALID=0 next cycle, REQ_READY=1, no 0x38/0x35 emitted; new request y=0xC then runs normally.
REQ-033 RST_N pulsed low mid-SCAN -> outputs at reset values asynchronously; REQ_VALID held 1 during busy time never causes a second accept.
